// File: rtl/rr_alu_sequencer_if.sv
// Control/status bundle between the R-type sequencer and the shared-bus datapath.
// The sequencer side is the master; the datapath (or a bench) is the slave.
interface rr_alu_sequencer_if #(
    parameter int NUM_REGS = 16
);
    logic                start;
    logic                mem_ready;
    logic [31:0]         ir;
    logic                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic                Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
    logic [NUM_REGS-1:0] Rin, Rout;
    logic [3:0]          ALUop;
    logic                ALU_MUL, ALU_DIV;
    logic                busy, done, illegal;

    modport master (
        input  start, mem_ready, ir,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
        output Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        output Rin, Rout, ALUop, ALU_MUL, ALU_DIV, busy, done, illegal
    );

    modport slave (
        output start, mem_ready, ir,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        input  Rin, Rout, ALUop, ALU_MUL, ALU_DIV, busy, done, illegal
    );
endinterface

// File: rtl/rr_alu_sequencer.sv
// Fetch/decode/execute sequencer for register-register ALU, MUL and DIV instructions.
// One state per bus cycle; all strobes are decoded from the registered state and ir.
module rr_alu_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic               clock,
    input  logic               clear,
    rr_alu_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ILL
    } state_t;

    typedef struct packed {
        logic       alu;
        logic       mul;
        logic       div;
        logic [3:0] aluop;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        logic       bad;
    } dec_t;

    typedef struct packed {
        logic                pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic                zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
        logic [NUM_REGS-1:0] rin, rout;
        logic [3:0]          aluop;
        logic                alu_mul, alu_div, busy, done, illegal;
    } strobe_t;

    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

    state_t      state, state_nx;
    logic        t1_wait;
    logic [31:0] opv;
    dec_t        dec;
    strobe_t     st;

    always_comb begin
        opv       = 32'(bus.ir[31:32-OPW]);
        dec       = '0;
        dec.ra    = bus.ir[26:23];
        dec.rb    = bus.ir[22:19];
        dec.rc    = bus.ir[18:15];
        if (opv <= 32'd8) begin
            dec.alu   = 1'b1;
            dec.aluop = opv[3:0];
        end else if (opv == 32'd15) begin
            dec.mul = 1'b1;
        end else if (opv == 32'd16) begin
            dec.div = 1'b1;
        end
        // R0 is write-protected only for ops that write Ra; MUL/DIV target LO/HI
        dec.bad = !(dec.alu || dec.mul || dec.div)
               || (32'(dec.ra) >= $unsigned(NUM_REGS))
               || (32'(dec.rb) >= $unsigned(NUM_REGS))
               || (32'(dec.rc) >= $unsigned(NUM_REGS))
               || (dec.alu && dec.ra == 4'd0);
    end

    // t1_wait marks every T1 cycle after the first, so PCin fires once per fetch
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_IDLE;
            t1_wait <= 1'b0;
        end else begin
            state   <= state_nx;
            t1_wait <= (state == S_T1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_T0;
            S_T0:    state_nx = S_T1;
            S_T1:    if (bus.mem_ready) state_nx = S_T2;
            S_T2:    state_nx = S_T3;
            S_T3:    state_nx = dec.bad ? S_ILL : S_T4;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = (dec.mul || dec.div) ? S_T6 : S_DONE;
            S_T6:    state_nx = S_DONE;
            S_DONE:  state_nx = bus.start ? S_T0 : S_IDLE;
            S_ILL:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        st = '0;
        case (state)
            S_T0: begin
                st.pc_out  = 1'b1;
                st.mar_in  = 1'b1;
                st.inc_pc  = 1'b1;
                st.zlow_in = 1'b1;
            end
            S_T1: begin
                st.zlow_out = 1'b1;
                st.pc_in    = !t1_wait;
                st.read     = 1'b1;
                st.mdr_in   = 1'b1;
            end
            S_T2: begin
                st.mdr_out = 1'b1;
                st.ir_in   = 1'b1;
            end
            S_T3: if (!dec.bad) begin
                st.rout = ONE << dec.rb;
                st.y_in = 1'b1;
            end
            S_T4: begin
                st.rout     = ONE << dec.rc;
                st.aluop    = dec.aluop;
                st.zlow_in  = 1'b1;
                st.zhigh_in = dec.mul || dec.div;
                st.alu_mul  = dec.mul;
                st.alu_div  = dec.div;
            end
            S_T5: begin
                st.zlow_out = 1'b1;
                if (dec.mul || dec.div) st.lo_in = 1'b1;
                else                    st.rin   = ONE << dec.ra;
            end
            S_T6: begin
                st.zhigh_out = 1'b1;
                st.hi_in     = 1'b1;
            end
            S_DONE:  st.done    = 1'b1;
            S_ILL:   st.illegal = 1'b1;
            default: ;
        endcase
        st.busy = (state != S_IDLE);
    end

    assign bus.PCout    = st.pc_out;
    assign bus.MARin    = st.mar_in;
    assign bus.IncPC    = st.inc_pc;
    assign bus.PCin     = st.pc_in;
    assign bus.Read     = st.read;
    assign bus.MDRin    = st.mdr_in;
    assign bus.MDRout   = st.mdr_out;
    assign bus.IRin     = st.ir_in;
    assign bus.Yin      = st.y_in;
    assign bus.Zlowin   = st.zlow_in;
    assign bus.Zhighin  = st.zhigh_in;
    assign bus.Zlowout  = st.zlow_out;
    assign bus.Zhighout = st.zhigh_out;
    assign bus.LOin     = st.lo_in;
    assign bus.HIin     = st.hi_in;
    assign bus.Rin      = st.rin;
    assign bus.Rout     = st.rout;
    assign bus.ALUop    = st.aluop;
    assign bus.ALU_MUL  = st.alu_mul;
    assign bus.ALU_DIV  = st.alu_div;
    assign bus.busy     = st.busy;
    assign bus.done     = st.done;
    assign bus.illegal  = st.illegal;
endmodule

// File: tb/tb_rr_alu_sequencer.sv
// Drives two sequencers (16 and 8 registers) with shared stimulus; a small bus
// datapath model follows the 16-register strobes and a scoreboard checks retirement.
module tb_rr_alu_sequencer;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = '0;

    always #5 clock = ~clock;

    rr_alu_sequencer_if #(.NUM_REGS(16)) b16 ();
    rr_alu_sequencer_if #(.NUM_REGS(8))  b8  ();

    assign b16.start = start;  assign b16.mem_ready = mem_ready;  assign b16.ir = ir;
    assign b8.start  = start;  assign b8.mem_ready  = mem_ready;  assign b8.ir  = ir;

    rr_alu_sequencer #(.NUM_REGS(16), .OPW(5)) dut16 (.clock(clock), .clear(clear), .bus(b16));
    rr_alu_sequencer #(.NUM_REGS(8),  .OPW(5)) dut8  (.clock(clock), .clear(clear), .bus(b8));

    typedef struct {
        int          cyc;
        bit          ill;
        int          dst;   // -1 none, 0..15 register, 16 LO/HI
        logic [31:0] v;
        logic [31:0] v2;
    } exp_t;

    exp_t        q16[$], q8[$];
    int          cyc = 0, n_vec = 0, n_err = 0;
    logic [31:0] regs[16];
    logic [31:0] y = '0, pc = '0, lo = '0, hi = '0;
    logic [63:0] z = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    function automatic logic [63:0] alu(input logic [3:0] op, input bit mul, input bit dv,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] r;
        s = b[4:0];
        if (mul) return {32'd0, a} * {32'd0, b};
        if (dv)  return {a % b, a / b};
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a >> s;
            4'd5:    r = a << s;
            4'd6:    r = $signed(a) >>> s;
            4'd7:    r = (a >> s) | (a << (6'd32 - {1'b0, s}));
            4'd8:    r = (a << s) | (a >> (6'd32 - {1'b0, s}));
            default: r = 'x;
        endcase
        return {32'd0, r};
    endfunction

    function automatic logic [63:0] outs16();
        return {b16.PCout, b16.MARin, b16.IncPC, b16.PCin, b16.Read, b16.MDRin, b16.MDRout,
                b16.IRin, b16.Yin, b16.Zlowin, b16.Zhighin, b16.Zlowout, b16.Zhighout,
                b16.LOin, b16.HIin, b16.Rin, b16.Rout, b16.ALUop, b16.ALU_MUL, b16.ALU_DIV,
                b16.busy, b16.done, b16.illegal};
    endfunction

    // Queue the retirement each DUT should produce for an instruction started this cycle
    task automatic expect_ret(input bit ill16, input bit ill8, input int dst,
                              input logic [31:0] v, input logic [31:0] v2, input int extra);
        exp_t e;
        int   lat;
        lat  = (dst == 16) ? 8 : 7;
        e.v  = v;  e.v2 = v2;
        e.ill = ill16;  e.dst = ill16 ? -1 : dst;
        e.cyc = cyc + (ill16 ? 5 : lat) + extra;
        q16.push_back(e);
        e.ill = ill8;  e.dst = -1;
        e.cyc = cyc + (ill8 ? 5 : lat) + extra;
        q8.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Datapath model and scoreboard, sampled mid-cycle
    always @(negedge clock) begin
        logic [31:0] bv;
        exp_t        e;
        bv = '0;
        for (int i = 0; i < 16; i++) if (b16.Rout[i]) bv = regs[i];
        if (b16.Zlowout)  bv = z[31:0];
        if (b16.Zhighout) bv = z[63:32];
        if (b16.PCout)    bv = pc;
        if (b16.Yin)      y = bv;
        if (b16.Zlowin)   z = b16.IncPC ? {32'd0, bv + 32'd1} : alu(b16.ALUop, b16.ALU_MUL, b16.ALU_DIV, y, bv);
        if (b16.PCin)     pc = bv;
        if (b16.LOin)     lo = bv;
        if (b16.HIin)     hi = bv;
        for (int i = 0; i < 16; i++) if (b16.Rin[i]) regs[i] = bv;

        chk("sel16_onehot", ($onehot0(b16.Rin) && $onehot0(b16.Rout) && !(|b16.Rin && |b16.Rout)) ? 1 : 0, 1);
        chk("sel8_onehot",  ($onehot0(b8.Rin)  && $onehot0(b8.Rout)  && !(|b8.Rin  && |b8.Rout))  ? 1 : 0, 1);

        if (b16.done || b16.illegal) begin
            if (q16.size() == 0) chk("sb16_spurious", {b16.done, b16.illegal}, 0);
            else begin
                e = q16.pop_front();
                chk("sb16_cycle", cyc, e.cyc);
                chk("sb16_kind", b16.illegal, e.ill);
                if (e.dst == 16) begin
                    chk("sb16_lo", lo, e.v);
                    chk("sb16_hi", hi, e.v2);
                end else if (e.dst >= 0) chk("sb16_reg", regs[e.dst], e.v);
            end
        end else if (q16.size() != 0 && cyc > q16[0].cyc) begin
            chk("sb16_timeout", cyc, q16[0].cyc);
            void'(q16.pop_front());
        end

        if (b8.done || b8.illegal) begin
            if (q8.size() == 0) chk("sb8_spurious", {b8.done, b8.illegal}, 0);
            else begin
                e = q8.pop_front();
                chk("sb8_cycle", cyc, e.cyc);
                chk("sb8_kind", b8.illegal, e.ill);
            end
        end else if (q8.size() != 0 && cyc > q8[0].cyc) begin
            chk("sb8_timeout", cyc, q8[0].cyc);
            void'(q8.pop_front());
        end
    end

    initial begin
        logic [15:0] rin_acc;
        logic [3:0]  wr;
        int          rd, pcin, zlo;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        #1 clear = 1'b0;
        #1 chk("reset_outputs", outs16(), 0);
        chk("reset_busy8", b8.busy, 0);
        #10 clear = 1'b1;
        step();

        // SHRA R7,R0,R4
        regs[0] = 32'hFFFF_FFF0;  regs[4] = 32'h0000_0002;
        ir = mk(6, 7, 0, 4);  start = 1'b1;
        expect_ret(0, 0, 7, 32'hFFFF_FFFC, 0, 0);
        step();  start = 1'b0;
        chk("t0_strobes", {b16.PCout, b16.MARin, b16.IncPC, b16.Zlowin}, 4'hF);
        step();
        chk("t1_strobes", {b16.Zlowout, b16.PCin, b16.Read, b16.MDRin}, 4'hF);
        step();
        chk("t2_strobes", {b16.MDRout, b16.IRin}, 2'b11);
        step();
        chk("shra_t3_rout", b16.Rout, 16'h0001);
        chk("shra_t3_yin", b16.Yin, 1);
        step();
        chk("shra_t4_rout", b16.Rout, 16'h0010);
        chk("shra_t4_aluop", {b16.ALUop, b16.Zlowin, b16.Zhighin}, {4'd6, 1'b1, 1'b0});
        step();
        chk("shra_t5_rin", {b16.Rin, b16.Zlowout}, {16'h0080, 1'b1});
        step();  step();
        chk("shra_idle_busy", b16.busy, 0);

        // MUL with Rb=R3, Rc=R5
        regs[3] = 32'h0001_0000;  regs[5] = 32'h0001_0000;
        ir = mk(15, 0, 3, 5);  start = 1'b1;
        expect_ret(0, 0, 16, 32'h0, 32'h1, 0);
        rin_acc = '0;
        for (int i = 0; i < 4; i++) begin step(); start = 1'b0; rin_acc |= b16.Rin; end
        step();  rin_acc |= b16.Rin;
        chk("mul_t4", {b16.Zhighin, b16.ALU_MUL, b16.ALU_DIV, b16.Zlowin, b16.ALUop}, {4'b1101, 4'd0});
        step();  rin_acc |= b16.Rin;
        chk("mul_t5", {b16.LOin, b16.Zlowout, b16.HIin}, 3'b110);
        step();  rin_acc |= b16.Rin;
        chk("mul_t6", {b16.HIin, b16.Zhighout, b16.LOin}, 3'b110);
        step();  rin_acc |= b16.Rin;
        chk("mul_no_rin", rin_acc, 0);
        step();

        // DIV 100 / 7
        regs[6] = 32'd100;  regs[7] = 32'd7;
        ir = mk(16, 0, 6, 7);  start = 1'b1;
        expect_ret(0, 0, 16, 32'd14, 32'd2, 0);
        for (int i = 0; i < 5; i++) begin step(); start = 1'b0; end
        chk("div_t4", {b16.ALU_DIV, b16.ALU_MUL, b16.Zhighin}, 3'b101);
        repeat (5) step();

        // ADD R1,R2,R3 with three wait cycles in T1
        regs[1] = '0;  regs[2] = 32'd5;  regs[3] = 32'd7;
        ir = mk(0, 1, 2, 3);  start = 1'b1;
        expect_ret(0, 0, 1, 32'd12, 0, 3);
        step();  start = 1'b0;  mem_ready = 1'b0;
        rd = 0;  pcin = 0;  zlo = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) chk("mem_pcin_first", b16.PCin, 1);
            if (i == 3) mem_ready = 1'b1;
            rd += int'(b16.Read & b16.MDRin);  pcin += int'(b16.PCin);  zlo += int'(b16.Zlowout);
        end
        chk("mem_read_cycles", rd, 4);
        chk("mem_pcin_count", pcin, 1);
        chk("mem_zlowout_cycles", zlo, 4);
        step();
        chk("mem_t2", {b16.MDRout, b16.IRin, b16.Read}, 3'b110);
        repeat (5) step();

        // Unknown opcode
        ir = mk(31, 1, 2, 3);  start = 1'b1;
        expect_ret(1, 1, -1, 0, 0, 0);
        wr = '0;
        for (int i = 0; i < 4; i++) begin
            step();  start = 1'b0;
            wr |= {|b16.Rin, b16.LOin, b16.HIin, (i == 3) ? b16.Yin : 1'b0};
        end
        chk("ill_t3_rout", b16.Rout, 0);
        step();
        chk("ill_pulse", {b16.illegal, b16.done}, 2'b10);
        wr |= {|b16.Rin, b16.LOin, b16.HIin, 1'b0};
        step();
        chk("ill_busy", b16.busy, 0);
        chk("ill_no_write", wr, 0);

        // Rc=9: legal with 16 registers, out of range with 8
        regs[2] = 32'd5;  regs[9] = 32'd3;
        ir = mk(0, 1, 2, 9);  start = 1'b1;
        expect_ret(0, 1, 1, 32'd8, 0, 0);
        wr = '0;
        for (int i = 0; i < 5; i++) begin
            step();  start = 1'b0;
            wr |= {|b8.Rin, b8.LOin, b8.HIin, 1'b0};
        end
        chk("ill8_pulse", b8.illegal, 1);
        chk("ill8_no_write", wr, 0);
        step();
        chk("ill8_busy", b8.busy, 0);
        chk("ill8_dut16_busy", b16.busy, 1);
        repeat (2) step();

        // ADD to R0 is illegal for both widths
        ir = mk(0, 0, 2, 3);  start = 1'b1;
        expect_ret(1, 1, -1, 0, 0, 0);
        step();  start = 1'b0;
        repeat (5) step();

        // Back-to-back SUBs with start held high
        regs[1] = '0;  regs[2] = 32'd5;  regs[3] = 32'd7;
        ir = mk(1, 1, 2, 3);  start = 1'b1;
        expect_ret(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        expect_ret(0, 0, 4, 32'hFFFF_FFF9, 0, 7);
        repeat (7) step();
        chk("b2b_done1", b16.done, 1);
        ir = mk(1, 4, 1, 2);
        step();  start = 1'b0;
        chk("b2b_t0", {b16.PCout, b16.busy}, 2'b11);
        repeat (7) step();

        // Asynchronous clear during T4
        regs[1] = 32'h0000_DEAD;
        ir = mk(0, 1, 2, 3);  start = 1'b1;
        for (int i = 0; i < 5; i++) begin step(); start = 1'b0; end
        chk("rst_t4_zlowin", b16.Zlowin, 1);
        #2 clear = 1'b0;
        #1 chk("rst_async_outputs", outs16(), 0);
        step();  clear = 1'b1;
        step();
        chk("rst_idle", b16.busy, 0);
        chk("rst_ra_unchanged", regs[1], 32'h0000_DEAD);

        repeat (3) step();
        chk("sb16_drain", q16.size(), 0);
        chk("sb8_drain", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
